// File: rtl/multiport_memory.sv
// multiport_memory
//   Single-write, multi-read memory built from 2**BANK_BITS low-order
//   interleaved banks. Each bank serves at most one read per cycle; ports
//   colliding on a bank are arbitrated by a per-bank round-robin pointer.
//   Granted reads return data one cycle later. A same-cycle write to the
//   address being read is forwarded (write-first).
//
// Ports
//   clk          : sole clock, rising edge
//   rst          : asynchronous active-high reset
//   write        : write enable
//   inaddr       : write word address [ADDR_W]
//   indata       : write data [DATA_W]
//   rd_req       : per-port read request [NUM_RD]
//   rd_addr      : per-port read address, port i at [i*ADDR_W +: ADDR_W]
//   rd_ack       : per-port grant, combinational, same cycle as the request
//   rd_valid     : per-port one-cycle data strobe, cycle after the grant
//   rd_data      : per-port read data, port i at [i*DATA_W +: DATA_W]
//   conflict_cnt : saturating count of cycles with at least one denied request
module multiport_memory #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 14,
    parameter int NUM_RD    = 4,
    parameter int BANK_BITS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     write,
    input  logic [ADDR_W-1:0]        inaddr,
    input  logic [DATA_W-1:0]        indata,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_ack,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [15:0]              conflict_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BANKS = 2 ** BANK_BITS;
    localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

    logic [DATA_W-1:0]    mem [DEPTH];
    logic [ADDR_W-1:0]    port_addr [NUM_RD];
    logic [BANK_BITS-1:0] port_bank [NUM_RD];
    logic [PTR_W-1:0]     ptr       [BANKS];
    logic [PTR_W-1:0]     ptr_nxt   [BANKS];
    logic [NUM_RD-1:0]    ack;
    logic                 denied;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            port_addr[i] = rd_addr[i*ADDR_W +: ADDR_W];
            port_bank[i] = port_addr[i][BANK_BITS-1:0];
        end
    end

    // Per-bank round-robin: scan ports starting at the bank's pointer and
    // grant the first one requesting this bank. Banks are independent, so
    // requests to distinct banks are all granted together.
    always_comb begin
        logic found;
        int   idx;
        // NOTE: combinational logic uses blocking '=' and gives every output a
        // default first, so no path leaves a value held (no latch).
        ack     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        if (!rst) begin
            for (int b = 0; b < BANKS; b++) begin
                found = 1'b0;
                for (int k = 0; k < NUM_RD; k++) begin
                    idx = (int'(ptr[b]) + k) % NUM_RD;
                    if (!found && rd_req[idx] && port_bank[idx] == BANK_BITS'(b)) begin
                        found      = 1'b1;
                        ack[idx]   = 1'b1;
                        ptr_nxt[b] = PTR_W'((idx + 1) % NUM_RD);
                    end
                end
            end
        end
    end

    assign rd_ack = ack;
    assign denied = |(rd_req & ~ack) && !rst;

    // NOTE: the storage array has no reset; clearing it would turn the RAM
    // into flops. Writes are blocked while rst is high so a write landing in
    // the reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (write && !rst) begin
            mem[inaddr] <= indata;
        end
    end

    // NOTE: all state below updates with non-blocking '<=' so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < BANKS; b++) begin
                ptr[b] <= '0;
            end
            rd_valid     <= '0;
            rd_data      <= '0;
            conflict_cnt <= '0;
        end else begin
            for (int b = 0; b < BANKS; b++) begin
                ptr[b] <= ptr_nxt[b];
            end
            rd_valid <= ack;
            for (int i = 0; i < NUM_RD; i++) begin
                if (ack[i]) begin
                    // Write-first: forward indata on a same-address write.
                    rd_data[i*DATA_W +: DATA_W] <=
                        (write && inaddr == port_addr[i]) ? indata : mem[port_addr[i]];
                end
            end
            if (denied && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_multiport_memory.sv
// tb_multiport_memory
//   Directed bench for multiport_memory with default parameters. Inputs
//   change 1 ns after the rising edge; outputs are sampled there too.
module tb_multiport_memory;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 14;
    localparam int NUM_RD = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     write;
    logic [ADDR_W-1:0]        inaddr;
    logic [DATA_W-1:0]        indata;
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_ack;
    logic [NUM_RD-1:0]        rd_valid;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [15:0]              conflict_cnt;

    int checks   = 0;
    int failures = 0;

    multiport_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .BANK_BITS(2)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .inaddr(inaddr), .indata(indata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int port, input logic [ADDR_W-1:0] a);
        rd_addr[port*ADDR_W +: ADDR_W] = a;
    endtask

    function automatic logic [DATA_W-1:0] port_data(input int port);
        return rd_data[port*DATA_W +: DATA_W];
    endfunction

    initial begin
        logic [DATA_W-1:0] vals [4];
        logic [NUM_RD-1:0] req;
        vals = '{10'h011, 10'h022, 10'h033, 10'h044};

        rst = 1'b1; write = 1'b0; inaddr = '0; indata = '0;
        rd_req = '0; rd_addr = '0;
        tick();
        tick();

        // Reset state; grants suppressed while in reset.
        rd_req = 4'b1111;
        #1;
        check("reset_ack",   32'(rd_ack), 32'h0);
        check("reset_valid", 32'(rd_valid), 32'h0);
        check("reset_data",  32'(rd_data), 32'h0);
        check("reset_cnt",   32'(conflict_cnt), 32'h0);
        rd_req = '0;
        tick();
        rst = 1'b0;
        tick();

        // Write then read back on port 0, latency 1.
        write = 1'b1; inaddr = 14'h0004; indata = 10'h155;
        tick();
        write = 1'b0;
        rd_req = 4'b0001; set_addr(0, 14'h0004);
        #1;
        check("wr_rd_ack", 32'(rd_ack), 32'h1);
        tick();
        rd_req = '0;
        check("wr_rd_valid", 32'(rd_valid), 32'h1);
        check("wr_rd_data",  32'(port_data(0)), 32'h155);
        tick();
        check("valid_one_cycle", 32'(rd_valid), 32'h0);
        check("data_held",       32'(port_data(0)), 32'h155);

        // Four distinct banks granted together, no conflict counted.
        for (int a = 0; a < 4; a++) begin
            write = 1'b1; inaddr = ADDR_W'(a); indata = vals[a];
            tick();
        end
        write = 1'b0;
        for (int p = 0; p < 4; p++) set_addr(p, ADDR_W'(p));
        rd_req = 4'b1111;
        #1;
        check("banks_ack", 32'(rd_ack), 32'hF);
        tick();
        rd_req = '0;
        check("banks_valid", 32'(rd_valid), 32'hF);
        for (int p = 0; p < 4; p++) check($sformatf("banks_data%0d", p), 32'(port_data(p)), 32'(vals[p]));
        check("banks_cnt", 32'(conflict_cnt), 32'h0);

        // Known word at 0x0008, then a write during a reset edge that must be dropped.
        write = 1'b1; inaddr = 14'h0008; indata = 10'h0AB;
        tick();
        rst = 1'b1; indata = 10'h3FF;
        tick();
        write = 1'b0; rst = 1'b0;
        tick();

        // All four ports on one address: round-robin 0,1,2,3; three conflict cycles.
        for (int p = 0; p < 4; p++) set_addr(p, 14'h0008);
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            rd_req = req;
            #1;
            check($sformatf("rr_ack%0d", k), 32'(rd_ack), 32'(1 << k));
            tick();
            check($sformatf("rr_valid%0d", k), 32'(rd_valid), 32'(1 << k));
            check($sformatf("rr_data%0d", k), 32'(port_data(k)), 32'h0AB);
            req[k] = 1'b0;
        end
        rd_req = '0;
        check("rr_cnt", 32'(conflict_cnt), 32'd3);

        // Write-first bypass on port 2.
        write = 1'b1; inaddr = 14'h0010; indata = 10'h2AA;
        set_addr(2, 14'h0010); rd_req = 4'b0100;
        #1;
        check("bypass_ack", 32'(rd_ack), 32'h4);
        tick();
        write = 1'b0; rd_req = '0;
        check("bypass_valid", 32'(rd_valid), 32'h4);
        check("bypass_data",  32'(port_data(2)), 32'h2AA);

        // Contention to count 5, then asynchronous reset mid-contention.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_addr(0, 14'h0000); set_addr(1, 14'h0004);
        rd_req = 4'b0011;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_cnt",   32'(conflict_cnt), 32'd5);
        check("pre_rst_valid", 32'(rd_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_valid", 32'(rd_valid), 32'h0);
        check("async_cnt",   32'(conflict_cnt), 32'h0);
        check("async_data",  32'(port_data(0)), 32'h0);
        check("async_ack",   32'(rd_ack), 32'h0);
        tick();
        rst = 1'b0;
        #1;
        check("post_rst_winner", 32'(rd_ack), 32'h1);

        // Permanent two-port conflict: counter climbs one per cycle then saturates.
        for (int k = 0; k < 100; k++) tick();
        check("sat_cnt_100", 32'(conflict_cnt), 32'd100);
        for (int k = 0; k < 69900; k++) tick();
        check("sat_cnt_max", 32'(conflict_cnt), 32'hFFFF);
        rd_req = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
